// File: rtl/kart_pkg.sv
// Shared kart link definitions: packet framing and link FSM states.
// Used by both the state transmitter and the opponent-side receiver.
package kart_pkg;

    localparam logic [7:0] PKT_HEADER = 8'hA5;
    localparam int         PKT_LEN    = 8;
    localparam logic [2:0] LAST_IDX   = 3'(PKT_LEN - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [8:0]  dir;
        logic [2:0]  gstat;
        logic        prst;
        logic [7:0]  seq;
    } snap_t;

endpackage

// File: rtl/pkt_xor.sv
// Packet checksum: XOR of the seven payload bytes that precede it.
module pkt_xor
(
    input  logic [6:0][7:0] bytes_in,
    output logic [7:0]      chk
);

    always_comb begin
        chk = 8'h00;
        for (int i = 0; i < 7; i++) begin
            chk = chk ^ bytes_in[i];
        end
    end

endmodule

// File: rtl/player_state_tx.sv
// Serialises a frame-synchronous snapshot of local kart state into an
// 8-byte packet on a valid/ready byte stream.
module player_state_tx
    import kart_pkg::*;
#(
    parameter logic [10:0] TRIG_H = 11'd1198,
    parameter logic [9:0]  TRIG_V = 10'd800,
    parameter logic [7:0]  HEADER = PKT_HEADER
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic [10:0] player_x,
    input  logic [10:0] player_y,
    input  logic [8:0]  player_direction,
    input  logic [2:0]  game_stat,
    input  logic        player_rst,
    input  logic        axiir,
    output logic        axiov,
    output logic [7:0]  axiod,
    output logic        busy,
    output logic [7:0]  seq
);

    state_t          state;
    logic [2:0]      idx;
    snap_t           snap;
    logic            trig;
    logic [6:0][7:0] body;
    logic [7:0][7:0] pkt;
    logic [7:0]      chk;

    assign trig = (hcount == TRIG_H) && (vcount == TRIG_V);

    assign body[0] = HEADER;
    assign body[1] = snap.seq;
    assign body[2] = snap.x[10:3];
    assign body[3] = {snap.x[2:0], snap.y[10:6]};
    assign body[4] = {snap.y[5:0], snap.dir[8:7]};
    assign body[5] = {snap.dir[6:0], snap.prst};
    assign body[6] = {snap.gstat, 5'b0};

    pkt_xor u_xor (
        .bytes_in(body),
        .chk     (chk)
    );

    assign pkt = {chk, body};

    always_comb begin
        axiov = 1'b0;
        axiod = 8'h00;
        busy  = 1'b0;
        if (state == SEND) begin
            axiov = 1'b1;
            axiod = pkt[idx];
            busy  = 1'b1;
        end
    end

    // Triggers seen while a packet is in flight are dropped, not queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= 3'd0;
            seq   <= 8'h00;
            snap  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (trig) begin
                        snap  <= '{x: player_x, y: player_y,
                                   dir: player_direction,
                                   gstat: game_stat,
                                   prst: player_rst, seq: seq};
                        idx   <= 3'd0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (axiir) begin
                        if (idx == LAST_IDX) begin
                            idx   <= 3'd0;
                            seq   <= seq + 8'd1;
                            state <= IDLE;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_player_state_tx.sv
// Directed + randomized bench for player_state_tx against a packet-level
// reference model built from the field layout of the packet.
module tb_player_state_tx;

    localparam logic [10:0] TH = 11'd1198;
    localparam logic [9:0]  TV = 10'd800;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [10:0] player_x;
    logic [10:0] player_y;
    logic [8:0]  player_direction;
    logic [2:0]  game_stat;
    logic        player_rst;
    logic        axiir;
    logic        axiov;
    logic [7:0]  axiod;
    logic        busy;
    logic [7:0]  seq;

    int         vectors = 0;
    int         errs    = 0;
    logic [7:0] model_seq;

    player_state_tx dut (
        .clk             (clk),
        .rst             (rst),
        .hcount          (hcount),
        .vcount          (vcount),
        .player_x        (player_x),
        .player_y        (player_y),
        .player_direction(player_direction),
        .game_stat       (game_stat),
        .player_rst      (player_rst),
        .axiir           (axiir),
        .axiov           (axiov),
        .axiod           (axiod),
        .busy            (busy),
        .seq             (seq)
    );

    always #5 clk = ~clk;

    // Packet as one 64-bit word: 56 payload bits then the checksum byte.
    function automatic logic [7:0] exp_byte(
        input int i, input logic [10:0] x, input logic [10:0] y,
        input logic [8:0] d, input logic [2:0] g, input logic p,
        input logic [7:0] s);
        logic [63:0] w;
        logic [7:0]  b [8];
        w = {8'hA5, s, x, y, d, p, g, 5'b0, 8'h00};
        for (int k = 0; k < 8; k++) b[k] = w[63 - 8*k -: 8];
        b[7] = 8'h00;
        for (int k = 0; k < 7; k++) b[7] = b[7] ^ b[k];
        return b[i];
    endfunction

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_axiov"}, {7'b0, axiov}, 8'h00);
        check({tag, "_busy"}, {7'b0, busy}, 8'h00);
        check({tag, "_axiod"}, axiod, 8'h00);
    endtask

    task automatic send_pkt(
        input logic [10:0] x, input logic [10:0] y, input logic [8:0] d,
        input logic [2:0] g, input logic p, input int stall_at,
        input int stall_n, input bit scramble, input bit retrig);
        logic [7:0] s;
        logic [7:0] e;
        s = model_seq;
        player_x = x;
        player_y = y;
        player_direction = d;
        game_stat = g;
        player_rst = p;
        hcount = TH;
        vcount = TV;
        axiir = 1'b1;
        step();
        hcount = 11'd0;
        vcount = 10'd0;
        for (int i = 0; i < 8; i++) begin
            e = exp_byte(i, x, y, d, g, p, s);
            if (scramble && i == 1) begin
                player_x = 11'd0;
                player_y = 11'd0;
                player_direction = 9'($urandom_range(359));
                game_stat = 3'($urandom);
                player_rst = ~p;
            end
            if (retrig) begin
                hcount = TH;
                vcount = TV;
            end
            for (int k = 0; k < ((i == stall_at) ? stall_n : 0); k++) begin
                axiir = 1'b0;
                check($sformatf("stall_v%0d", i), {7'b0, axiov}, 8'h01);
                check($sformatf("stall_b%0d", i), axiod, e);
                check($sformatf("stall_busy%0d", i), {7'b0, busy}, 8'h01);
                step();
            end
            axiir = 1'b1;
            check($sformatf("v%0d", i), {7'b0, axiov}, 8'h01);
            check($sformatf("b%0d", i), axiod, e);
            check($sformatf("busy%0d", i), {7'b0, busy}, 8'h01);
            step();
        end
        hcount = 11'd0;
        vcount = 10'd0;
        model_seq = model_seq + 8'd1;
        check_idle("post");
        check("seq", seq, model_seq);
        if (retrig) begin
            step();
            check_idle("retrig");
        end
    endtask

    initial begin
        rst = 1'b1;
        hcount = 11'd0;
        vcount = 10'd0;
        player_x = 11'd0;
        player_y = 11'd0;
        player_direction = 9'd0;
        game_stat = 3'd0;
        player_rst = 1'b0;
        axiir = 1'b1;
        model_seq = 8'h00;
        step();
        step();
        check_idle("rst");
        check("rst_seq", seq, 8'h00);

        hcount = TH;
        vcount = TV;
        step();
        check_idle("trig_in_rst");
        rst = 1'b0;
        hcount = TH - 11'd1;
        step();
        check_idle("near_trig");
        hcount = TH;
        vcount = TV - 10'd1;
        step();
        check_idle("near_trig_v");

        send_pkt(11'd400, 11'd400, 9'd90, 3'd2, 1'b0, -1, 0, 0, 0);
        send_pkt(11'd400, 11'd400, 9'd90, 3'd2, 1'b0, 3, 3, 0, 0);
        send_pkt(11'd1234, 11'd777, 9'd359, 3'd5, 1'b1, -1, 0, 1, 0);
        send_pkt(11'd0, 11'd0, 9'd17, 3'd1, 1'b0, -1, 0, 0, 0);
        send_pkt(11'd55, 11'd66, 9'd200, 3'd7, 1'b1, 5, 2, 0, 1);

        player_x = 11'd400;
        player_y = 11'd400;
        player_direction = 9'd90;
        game_stat = 3'd2;
        player_rst = 1'b0;
        hcount = TH;
        vcount = TV;
        axiir = 1'b1;
        step();
        hcount = 11'd0;
        vcount = 10'd0;
        for (int i = 0; i < 4; i++) step();
        axiir = 1'b0;
        check("pend_b4", axiod,
              exp_byte(4, 11'd400, 11'd400, 9'd90, 3'd2, 1'b0, model_seq));
        rst = 1'b1;
        step();
        rst = 1'b0;
        axiir = 1'b1;
        model_seq = 8'h00;
        check_idle("abort");
        check("abort_seq", seq, 8'h00);
        send_pkt(11'd9, 11'd10, 9'd11, 3'd3, 1'b1, -1, 0, 0, 0);

        for (int n = 0; n < 256; n++) begin
            send_pkt(11'($urandom), 11'($urandom),
                     9'($urandom_range(359)), 3'($urandom),
                     1'($urandom), int'($urandom_range(7)),
                     int'($urandom_range(2)), 0, 0);
        end
        check("wrap_seq", seq, 8'h01);
        send_pkt(11'($urandom), 11'($urandom), 9'($urandom_range(359)),
                 3'($urandom), 1'($urandom), -1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/player_state_tx.md
PLAYER_STATE_TX -- requirements
Module: player_state_tx

Interface
REQ-001 Parameter TRIG_H, default 1198: hcount value that starts a packet.
REQ-002 Parameter TRIG_V, default 800: vcount value that starts a packet.
REQ-003 Parameter HEADER, default 8'hA5: first byte of every packet.
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 hcount  in  11  pixel column counter from video timing.
REQ-007 vcount  in  10  pixel row counter from video timing.
REQ-008 player_x  in  11  local kart x position.
REQ-009 player_y  in  11  local kart y position.
REQ-010 player_direction  in  9  local heading in degrees (0-359).
REQ-011 game_stat  in  3  local game state.
REQ-012 player_rst  in  1  local player-reset flag sent to the opponent.
REQ-013 axiir  in  1  downstream ready.
REQ-014 axiov  out  1  byte valid.
REQ-015 axiod  out  8  byte data.
REQ-016 busy  out  1  high from packet start until the last byte is accepted.
REQ-017 seq  out  8  count of completed packets.

Function
REQ-018 Trigger: hcount==TRIG_H && vcount==TRIG_V while in IDLE; other values and any trigger outside IDLE are ignored, with no queueing.
REQ-019 Trigger cycle N: snapshot player_x, player_y, player_direction, game_stat, player_rst and seq into a register; later input changes do not affect the packet in flight.
REQ-020 Cycle N+1: axiov=1, axiod=byte0, busy=1.
REQ-021 Packet format, 8 bytes, MSB first: b0=HEADER; b1=seq; b2=x[10:3]; b3={x[2:0],y[10:6]}; b4={y[5:0],dir[8:7]}; b5={dir[6:0],player_rst}; b6={game_stat,5'b0}; b7=XOR of b0..b6.
REQ-022 States: IDLE -> SEND on trigger; SEND -> IDLE when byte7 transfers (axiov&&axiir, byte index 7).
REQ-023 A byte transfers only on axiov&&axiir; the byte index advances only on a transfer.
REQ-024 While axiir=0, axiod and axiov stay stable.
REQ-025 With axiir held at 1, the packet occupies 8 consecutive cycles (N+1..N+8), and busy=0 and axiov=0 at N+9.
REQ-026 seq increments by 1, modulo 256 (wraps 255->0), in the cycle byte7 transfers.
REQ-027 A trigger coincident with the final transfer is ignored, because the state is still SEND.
REQ-028 In IDLE, axiov=0 and axiod=8'h00.

Reset
REQ-029 While rst=1: state=IDLE, byte index=0, axiov=0, axiod=0, busy=0, seq=0, snapshot register cleared.
REQ-030 rst asserted mid-packet aborts it at the next edge; no further bytes are driven and seq does not increment.
REQ-031 A trigger coincident with rst=1 is ignored.

Structure
REQ-032 HEADER value, packet length (8) and the state enum (IDLE, SEND) are defined in shared package kart_pkg, which the receiver also uses.
REQ-033 Checksum generation (7-byte XOR) is a separate combinational sub-module, pkt_xor.
REQ-034 Everything else is a single always_ff plus a byte-select mux; no memories.

Verification
REQ-035 Reset; x=400, y=400, dir=90, player_rst=0, game_stat=2; hcount 1198, vcount 800; axiir=1 -> bytes A5 00 32 06 40 B4 40 25 on N+1..N+8; seq=1 afterwards.
REQ-036 Same as REQ-035, but axiir=0 for 3 cycles at byte3 -> axiod holds 06 with axiov=1 for those cycles; full packet intact, 11 cycles total.
REQ-037 Inputs changed to x=0, y=0 during SEND -> in-flight packet unchanged; next packet has b2=00 and b3=00.
REQ-038 Second trigger (hcount 1198, vcount 800) during SEND -> ignored; exactly one packet emitted.
REQ-039 rst pulsed while byte4 is pending -> axiov=0 next cycle, seq=0, busy=0; next trigger emits b1=00.
REQ-040 256 packets sent back-to-back -> seq wraps to 0; packet 257 carries b1=00 and its checksum recomputes correctly.
